shift_seq_unit: RTL and testbench
=================================

Name: shift_seq_unit

Overview:
Parametrised multi-cycle shift sequencer; successor to the single-step universal shift register. Loads a WIDTH-bit word, then on a start command performs a programmed number of single-bit shifts (one per clock) in a selected direction and mode: logical, arithmetic or rotate. Has a busy/done handshake and serial output. Used as a serialiser or bit-manipulation engine under a controlling FSM.

Parameters:
WIDTH, 8, data/register width (>=2)
CNT_W, 4, width of shift-amount field; max programmable amount = 2**CNT_W-1

Ports:
clk  input  1  clock, rising edge
clr  input  1  asynchronous reset, active low
D  input  WIDTH  parallel load data
ld  input  1  parallel load request
start  input  1  begin shift sequence
abort  input  1  terminate running sequence
dir  input  1  0 = right (towards bit 0), 1 = left
mode  input  2  00 logical, 01 arithmetic, 10 rotate, 11 treated as logical
amount  input  CNT_W  number of single-bit shifts
ser_in  input  1  fill bit for logical mode
Q  output  WIDTH  register contents
ser_out  output  1  last bit shifted out
busy  output  1  high while in SHIFT
done  output  1  one-cycle completion pulse

Behaviour:
- Reset (clr=0, async): Q=0, ser_out=0, state=IDLE, cnt=0, busy=0, done=0, latched dir/mode=0.
- States: IDLE, SHIFT, DONE. busy=(state==SHIFT); done=(state==DONE). Both are decoded from registered state (no combinational path from inputs).
- Commands (ld, start) are accepted only in IDLE or DONE.
- ld priority: ld>start. If both are high, only the load occurs: Q<=D and state->IDLE.
- start alone: latch dir, mode and amount into internal registers.
  - amount!=0: cnt<=amount, ->SHIFT.
  - amount==0: ->DONE; Q and ser_out unchanged.
- DONE without a new command: ->IDLE next edge. A start accepted in DONE gives back-to-back sequences, and done still pulses for exactly one cycle.
- SHIFT, each edge: one single-bit shift of Q using the latched dir/mode; cnt<=cnt-1; ser_out<=bit shifted out (Q[0] for right, Q[WIDTH-1] for left). When cnt==1 at the edge, ->DONE.
- ld and start are ignored in SHIFT. Changes to dir, mode or amount after acceptance have no effect.
- Shift rules:
  - Right logical: {ser_in,Q[W-1:1]}.
  - Right arithmetic: {Q[W-1],Q[W-1:1]}.
  - Right rotate: {Q[0],Q[W-1:1]}.
  - Left logical: {Q[W-2:0],ser_in}.
  - Left arithmetic: {Q[W-2:0],1'b0}.
  - Left rotate: {Q[W-2:0],Q[W-1]}.
- Latency: start sampled at edge 0 -> shifts at edges 1..N -> done high from edge N to edge N+1. Total N+1 cycles to done.
- amount>WIDTH is legal. Logical/arithmetic saturate naturally (all fill bits); rotate wraps modulo WIDTH.
- abort in SHIFT: ->IDLE at that edge, no shift that cycle, Q and ser_out hold, no done pulse. abort has priority over the shift. In IDLE/DONE, abort is ignored.
- Async clr mid-sequence: immediate return to reset values. No done pulse.
- Q holds its value in IDLE/DONE when no ld is present.

Decomposition:
- Shared package: state encoding constants (ST_IDLE=2'd0, ST_SHIFT=2'd1, ST_DONE=2'd2), mode constants (MODE_LOG, MODE_ARI, MODE_ROT), dir constants.
- One combinational sub-module, shift_step_1b: inputs Q, dir, mode, ser_in; outputs next Q and the out-bit. Instantiated once.
- FSM/counter stays in the top level.

Test Plan:
- WIDTH=8. ld D=8'h96. start, dir=0, mode=00, amount=3, ser_in=1 -> Q=CB, E5, F2 on edges 1-3; ser_out=1; busy high 3 cycles; done pulse at cycle 4.
- Q=8'h96, arithmetic right, amount=2 -> Q=8'hE5; ser_out=1. Then arithmetic left, amount=1 -> Q=8'hCA, ser_out=1.
- Q=8'h96, rotate left, amount=4 -> Q=8'h69. Rotate right, amount=12 -> Q=8'h96, i.e. the wrap.
- start with amount=0 -> no Q change; busy never high; done pulses the next cycle. ld and start together -> Q=D, no sequence.
- Mid-SHIFT abort after 2 of 5 shifts -> Q holds the 2-shift value, state IDLE, no done. Mid-SHIFT ld/start -> ignored.
- Async clr low mid-SHIFT (between edges) -> Q, busy, done, ser_out all 0 immediately. After release, ld and a new start work normally. Back-to-back start during DONE -> done pulses twice, no idle gap.

Source files
------------

// File: rtl/shift_seq_unit_pkg.sv
// Shared definitions for the shift sequencer: FSM state encoding,
// shift-mode codes and shift-direction codes.
package shift_seq_unit_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic [1:0] MODE_LOG = 2'b00;
    localparam logic [1:0] MODE_ARI = 2'b01;
    localparam logic [1:0] MODE_ROT = 2'b10;

    localparam logic DIR_RIGHT = 1'b0;
    localparam logic DIR_LEFT  = 1'b1;

endpackage

// File: rtl/shift_seq_unit_shift_step_1b.sv
// Combinational single-bit shift step used by the sequencer.
// Ports:
//   q       current register value
//   dir     0 = right (towards bit 0), 1 = left
//   mode    logical / arithmetic / rotate (code 11 behaves as logical)
//   ser_in  fill bit for logical shifts
//   q_next  value after one shift
//   out_bit bit leaving the register this step
module shift_step_1b
    import shift_seq_unit_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] q,
    input  logic             dir,
    input  logic [1:0]       mode,
    input  logic             ser_in,
    output logic [WIDTH-1:0] q_next,
    output logic             out_bit
);

    always_comb begin
        q_next  = q;
        out_bit = q[0];
        if (dir == DIR_RIGHT) begin
            out_bit = q[0];
            case (mode)
                MODE_ARI: q_next = {q[WIDTH-1], q[WIDTH-1:1]};
                MODE_ROT: q_next = {q[0], q[WIDTH-1:1]};
                default:  q_next = {ser_in, q[WIDTH-1:1]};
            endcase
        end else begin
            out_bit = q[WIDTH-1];
            case (mode)
                MODE_ARI: q_next = {q[WIDTH-2:0], 1'b0};
                MODE_ROT: q_next = {q[WIDTH-2:0], q[WIDTH-1]};
                default:  q_next = {q[WIDTH-2:0], ser_in};
            endcase
        end
    end

endmodule

// File: rtl/shift_seq_unit.sv
// Multi-cycle shift sequencer: parallel load, then a programmed number of
// single-bit shifts (one per clock) with a busy/done handshake.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | waiting for ld/start, Q holds
// ST_SHIFT | one shift per edge, cnt counts down to the last shift
// ST_DONE  | one-cycle completion; ld/start still accepted here
//
// Ports:
//   clk, clr       clock (rising edge), async active-low reset
//   D, ld          parallel load data and request (ld beats start)
//   start, abort   begin / terminate a sequence
//   dir, mode      direction and shift mode, latched at start
//   amount         number of shifts, latched at start (0 = straight to done)
//   ser_in         fill bit for logical shifts (sampled live each shift)
//   Q, ser_out     register contents, last bit shifted out
//   busy, done     decoded from the registered state
module shift_seq_unit
    import shift_seq_unit_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [WIDTH-1:0] D,
    input  logic             ld,
    input  logic             start,
    input  logic             abort,
    input  logic             dir,
    input  logic [1:0]       mode,
    input  logic [CNT_W-1:0] amount,
    input  logic             ser_in,
    output logic [WIDTH-1:0] Q,
    output logic             ser_out,
    output logic             busy,
    output logic             done
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_q;
    logic [WIDTH-1:0] q_q;
    logic             ser_out_q;
    logic [CNT_W-1:0] cnt_q;
    logic             dir_q;
    logic [1:0]       mode_q;

    logic [WIDTH-1:0] shift_q_d;
    logic             shift_out_d;

    shift_step_1b #(.WIDTH(WIDTH)) u_step (
        .q       (q_q),
        .dir     (dir_q),
        .mode    (mode_q),
        .ser_in  (ser_in),
        .q_next  (shift_q_d),
        .out_bit (shift_out_d)
    );

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q   <= ST_IDLE;
            q_q       <= '0;
            ser_out_q <= 1'b0;
            cnt_q     <= '0;
            dir_q     <= 1'b0;
            mode_q    <= 2'b00;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (ld) begin
                        q_q     <= D;
                        state_q <= ST_IDLE;
                    end else if (start) begin
                        dir_q  <= dir;
                        mode_q <= mode;
                        if (amount != '0) begin
                            cnt_q   <= amount;
                            state_q <= ST_SHIFT;
                        end else begin
                            state_q <= ST_DONE;
                        end
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_SHIFT: begin
                    // abort wins over the shift: nothing moves this edge
                    if (abort) begin
                        state_q <= ST_IDLE;
                    end else begin
                        q_q       <= shift_q_d;
                        ser_out_q <= shift_out_d;
                        cnt_q     <= cnt_q - CNT_ONE;
                        if (cnt_q == CNT_ONE) begin
                            state_q <= ST_DONE;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign Q       = q_q;
    assign ser_out = ser_out_q;
    assign busy    = (state_q == ST_SHIFT);
    assign done    = (state_q == ST_DONE);

endmodule

// File: tb/tb_shift_seq_unit.sv
module tb_shift_seq_unit;

    logic       clk = 1'b0;
    logic       clr = 1'b0;
    logic [7:0] D = '0;
    logic       ld = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       dir = 1'b0;
    logic [1:0] mode = 2'b00;
    logic [3:0] amount = '0;
    logic       ser_in = 1'b0;
    logic [7:0] Q;
    logic       ser_out;
    logic       busy;
    logic       done;

    int checks = 0;
    int errors = 0;

    shift_seq_unit #(.WIDTH(8), .CNT_W(4)) dut (
        .clk     (clk),
        .clr     (clr),
        .D       (D),
        .ld      (ld),
        .start   (start),
        .abort   (abort),
        .dir     (dir),
        .mode    (mode),
        .amount  (amount),
        .ser_in  (ser_in),
        .Q       (Q),
        .ser_out (ser_out),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [7:0] val);
        D  = val;
        ld = 1'b1;
        tick();
        ld = 1'b0;
    endtask

    // applies start for exactly one edge (edge 0 of the sequence)
    task automatic kick(input logic d, input logic [1:0] m, input logic [3:0] a);
        dir    = d;
        mode   = m;
        amount = a;
        start  = 1'b1;
        tick();
        start  = 1'b0;
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_flags(input string name, input logic b, input logic d,
                             input logic eb, input logic ed);
        checks++;
        if ({b, d} !== {eb, ed}) begin
            errors++;
            $display("FAIL %s: busy/done got %b%b expected %b%b", name, b, d, eb, ed);
        end
    endtask

    task automatic test_reset();
        clr = 1'b0;
        #3;
        chk("reset_Q", Q, 8'h00);
        chk("reset_ser_out", {7'd0, ser_out}, 8'h00);
        chk_flags("reset_flags", busy, done, 1'b0, 1'b0);
        @(negedge clk);
        clr = 1'b1;
        tick();
        chk("reset_hold_Q", Q, 8'h00);
    endtask

    task automatic test_logical_right();
        load(8'h96);
        chk("ld_Q", Q, 8'h96);
        ser_in = 1'b1;
        kick(1'b0, 2'b00, 4'd3);
        chk("lr_e0_Q", Q, 8'h96);
        chk_flags("lr_e0_flags", busy, done, 1'b1, 1'b0);
        tick();
        chk("lr_e1_Q", Q, 8'hCB);
        chk_flags("lr_e1_flags", busy, done, 1'b1, 1'b0);
        tick();
        chk("lr_e2_Q", Q, 8'hE5);
        chk_flags("lr_e2_flags", busy, done, 1'b1, 1'b0);
        tick();
        chk("lr_e3_Q", Q, 8'hF2);
        chk("lr_ser_out", {7'd0, ser_out}, 8'h01);
        chk_flags("lr_done", busy, done, 1'b0, 1'b1);
        tick();
        chk_flags("lr_idle", busy, done, 1'b0, 1'b0);
        chk("lr_hold_Q", Q, 8'hF2);
        ser_in = 1'b0;
    endtask

    task automatic test_arithmetic();
        load(8'h96);
        kick(1'b0, 2'b01, 4'd2);
        tick();
        tick();
        chk("ar_Q", Q, 8'hE5);
        chk("ar_ser_out", {7'd0, ser_out}, 8'h01);
        tick();
        kick(1'b1, 2'b01, 4'd1);
        tick();
        chk("al_Q", Q, 8'hCA);
        chk("al_ser_out", {7'd0, ser_out}, 8'h01);
        chk_flags("al_done", busy, done, 1'b0, 1'b1);
        tick();
    endtask

    task automatic test_rotate();
        load(8'h96);
        kick(1'b1, 2'b10, 4'd4);
        repeat (4) tick();
        chk("rl_Q", Q, 8'h69);
        chk("rl_ser_out", {7'd0, ser_out}, 8'h01);
        tick();
        kick(1'b0, 2'b10, 4'd12);
        repeat (11) tick();
        chk_flags("rr_busy_last", busy, done, 1'b1, 1'b0);
        tick();
        chk("rr_wrap_Q", Q, 8'h96);
        chk("rr_ser_out", {7'd0, ser_out}, 8'h01);
        chk_flags("rr_done", busy, done, 1'b0, 1'b1);
        tick();
    endtask

    task automatic test_zero_and_ld_priority();
        load(8'h3A);
        kick(1'b0, 2'b00, 4'd0);
        chk("zero_Q", Q, 8'h3A);
        chk_flags("zero_flags", busy, done, 1'b0, 1'b1);
        tick();
        chk_flags("zero_after", busy, done, 1'b0, 1'b0);
        D = 8'h5A;
        ld = 1'b1;
        kick(1'b0, 2'b00, 4'd3);
        ld = 1'b0;
        chk("ldstart_Q", Q, 8'h5A);
        chk_flags("ldstart_flags", busy, done, 1'b0, 1'b0);
        tick();
        chk_flags("ldstart_flags2", busy, done, 1'b0, 1'b0);
        chk("ldstart_Q2", Q, 8'h5A);
    endtask

    task automatic test_abort();
        load(8'h96);
        ser_in = 1'b0;
        kick(1'b0, 2'b00, 4'd5);
        tick();
        tick();
        chk("ab_pre_Q", Q, 8'h25);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("ab_Q", Q, 8'h25);
        chk("ab_ser_out", {7'd0, ser_out}, 8'h01);
        chk_flags("ab_flags", busy, done, 1'b0, 1'b0);
        tick();
        chk_flags("ab_no_done", busy, done, 1'b0, 1'b0);
        chk("ab_hold_Q", Q, 8'h25);
    endtask

    task automatic test_ignored_cmds();
        load(8'h96);
        kick(1'b0, 2'b10, 4'd3);
        D = 8'h00;
        ld = 1'b1;
        start = 1'b1;
        dir = 1'b1;
        mode = 2'b00;
        amount = 4'd1;
        tick();
        chk("ign_e1_Q", Q, 8'h4B);
        tick();
        chk("ign_e2_Q", Q, 8'hA5);
        chk_flags("ign_e2_flags", busy, done, 1'b1, 1'b0);
        ld = 1'b0;
        start = 1'b0;
        tick();
        chk("ign_e3_Q", Q, 8'hD2);
        chk_flags("ign_done", busy, done, 1'b0, 1'b1);
        tick();
    endtask

    task automatic test_async_clr();
        load(8'hFF);
        kick(1'b1, 2'b00, 4'd4);
        tick();
        #2;
        clr = 1'b0;
        #1;
        chk("clr_Q", Q, 8'h00);
        chk("clr_ser_out", {7'd0, ser_out}, 8'h00);
        chk_flags("clr_flags", busy, done, 1'b0, 1'b0);
        @(negedge clk);
        clr = 1'b1;
        tick();
        chk_flags("clr_after", busy, done, 1'b0, 1'b0);
        load(8'h3C);
        ser_in = 1'b1;
        kick(1'b1, 2'b00, 4'd2);
        tick();
        chk("post_clr_e1", Q, 8'h79);
        tick();
        chk("post_clr_e2", Q, 8'hF3);
        chk_flags("post_clr_done", busy, done, 1'b0, 1'b1);
        ser_in = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        load(8'h96);
        kick(1'b0, 2'b00, 4'd1);
        tick();
        chk("b2b_1_Q", Q, 8'h4B);
        chk_flags("b2b_1_done", busy, done, 1'b0, 1'b1);
        kick(1'b1, 2'b01, 4'd2);
        chk_flags("b2b_no_gap", busy, done, 1'b1, 1'b0);
        tick();
        chk("b2b_2_e1", Q, 8'h96);
        tick();
        chk("b2b_2_Q", Q, 8'h2C);
        chk_flags("b2b_2_done", busy, done, 1'b0, 1'b1);
        tick();
        chk_flags("b2b_end", busy, done, 1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_logical_right();
        test_arithmetic();
        test_rotate();
        test_zero_and_ld_priority();
        test_abort();
        test_ignored_cmds();
        test_async_clr();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
